// File: rtl/elc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elc_pkg
// Description : Shared state type and default constants for the multi-code
//               electronic lock.
// Revision    : 1.0
// ============================================================================
package elc_pkg;

    localparam int          ELC_DIGIT_W     = 3;
    localparam int          ELC_CODE_LEN    = 4;
    localparam logic [11:0] ELC_CODE        = 12'o2413;
    localparam int          ELC_LVALUE      = 5;
    localparam int          ELC_SVALUE      = 10;
    localparam int          ELC_MAX_TRIES   = 3;
    localparam int          ELC_LOCK_CYCLES = 20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_ERROR   = 3'd4,
        ST_LOCKOUT = 3'd5
    } elc_state_t;

    function automatic int elc_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elc_multi_code_if.sv
`default_nettype none
// ============================================================================
// Module      : elc_multi_code_if
// Description : Keypad/card/door signal bundle for the multi-code lock.
// Revision    : 1.0
// ============================================================================
interface elc_multi_code_if
    import elc_pkg::*;
#(
    parameter int DIGIT_W = ELC_DIGIT_W
);
    logic [DIGIT_W-1:0] in;
    logic               card_is_in;
    logic               enter;
    logic               unlock;
    logic               error;
    logic               card_is_needed;
    logic               locked_out;

    // master drives the keypad/card side, slave is the lock controller
    modport master (
        output in, card_is_in, enter,
        input  unlock, error, card_is_needed, locked_out
    );

    modport slave (
        input  in, card_is_in, enter,
        output unlock, error, card_is_needed, locked_out
    );
endinterface
`default_nettype wire

// File: rtl/elc_timer.sv
`default_nettype none
// ============================================================================
// Module      : elc_timer
// Description : Loadable down-counter; expired is high on the last counted cycle.
// Revision    : 1.0
// ============================================================================
module elc_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // a loaded value of N gives N cycles, the N-th one flagged as expired
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0) || (count_q == W'(1));

endmodule
`default_nettype wire

// File: rtl/elc_multi_code.sv
`default_nettype none
// ============================================================================
// Module      : elc_multi_code
// Description : Card-gated multi-digit code lock with timeout and error hold.
//               Define ELC_LOCKOUT_EN to add failure counting and lockout.
// Revision    : 1.0
// ============================================================================
module elc_multi_code
    import elc_pkg::*;
#(
    parameter int                            DIGIT_W     = ELC_DIGIT_W,
    parameter int                            CODE_LEN    = ELC_CODE_LEN,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   CODE        = ELC_CODE,
    parameter int                            LVALUE      = ELC_LVALUE,
    parameter int                            SVALUE      = ELC_SVALUE,
    parameter int                            MAX_TRIES   = ELC_MAX_TRIES,
    parameter int                            LOCK_CYCLES = ELC_LOCK_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    elc_multi_code_if.slave  bus
);

    localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TMR_W = $clog2(elc_max3(LVALUE, SVALUE, LOCK_CYCLES) + 1);

    if ((CODE_LEN < 1) || (CODE_LEN > 16) || (MAX_TRIES < 1)) begin : g_bad_cfg
        $error("elc_multi_code: unsupported CODE_LEN or MAX_TRIES");
    end

    elc_state_t                   state_q;
    elc_state_t                   state_d;
    logic [IDX_W-1:0]             idx_q;
    logic [IDX_W-1:0]             idx_d;
    logic [CODE_LEN*DIGIT_W-1:0]  digits_q;
    logic [CODE_LEN*DIGIT_W-1:0]  digits_d;
    logic                         tmr_load;
    logic [TMR_W-1:0]             tmr_val;
    logic                         tmr_expired;

`ifdef ELC_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    logic [FAIL_W-1:0] fail_q;
    logic [FAIL_W-1:0] fail_d;
    logic [FAIL_W-1:0] fail_sat;

    assign fail_sat = (fail_q == FAIL_W'(MAX_TRIES)) ? fail_q : fail_q + FAIL_W'(1);
`endif

    elc_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        digits_d = digits_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef ELC_LOCKOUT_EN
        fail_d   = fail_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.card_is_in) begin
                    state_d  = ST_ENTRY;
                    idx_d    = '0;
                    digits_d = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SVALUE);
                end
            end
            ST_ENTRY: begin
                // card removal outranks a keypress; a keypress outranks the timeout
                if (!bus.card_is_in) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (bus.enter) begin
                    for (int k = 0; k < CODE_LEN; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            digits_d[(CODE_LEN-1-k)*DIGIT_W +: DIGIT_W] = bus.in;
                        end
                    end
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SVALUE);
                    if (idx_q == IDX_W'(CODE_LEN - 1)) begin
                        state_d = ST_CHECK;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (tmr_expired) begin
                    state_d  = ST_ERROR;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SVALUE);
`ifdef ELC_LOCKOUT_EN
                    fail_d   = fail_sat;
`endif
                end
            end
            ST_CHECK: begin
                tmr_load = 1'b1;
                if (digits_q == CODE) begin
                    state_d = ST_OPEN;
                    tmr_val = TMR_W'(LVALUE);
`ifdef ELC_LOCKOUT_EN
                    fail_d  = '0;
`endif
                end else begin
                    state_d = ST_ERROR;
                    tmr_val = TMR_W'(SVALUE);
`ifdef ELC_LOCKOUT_EN
                    fail_d  = fail_sat;
`endif
                end
            end
            ST_OPEN: begin
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (tmr_expired) begin
`ifdef ELC_LOCKOUT_EN
                    if (fail_q == FAIL_W'(MAX_TRIES)) begin
                        state_d  = ST_LOCKOUT;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(LOCK_CYCLES);
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_LOCKOUT: begin
`ifdef ELC_LOCKOUT_EN
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            digits_q <= digits_d;
        end
    end

`ifdef ELC_LOCKOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fail_q <= '0;
        end else begin
            fail_q <= fail_d;
        end
    end

    assign bus.locked_out = (state_q == ST_LOCKOUT);
    assign bus.error      = (state_q == ST_ERROR) || (state_q == ST_LOCKOUT);
`else
    assign bus.locked_out = 1'b0;
    assign bus.error      = (state_q == ST_ERROR);
`endif

    assign bus.card_is_needed = (state_q == ST_IDLE);
    assign bus.unlock         = (state_q == ST_OPEN);

endmodule
`default_nettype wire

// File: tb/tb_elc_multi_code.sv
`default_nettype none
// ============================================================================
// Module      : tb_elc_multi_code
// Description : Directed bench for elc_multi_code with a cycle-level reference
//               model; follows ELC_LOCKOUT_EN when defined.
// Revision    : 1.0
// ============================================================================
module tb_elc_multi_code;

    localparam int          LEN    = 4;
    localparam logic [11:0] CODE   = 12'o2413;
    localparam int          LVAL   = 5;
    localparam int          SVAL   = 10;
    localparam int          TRIES  = 3;
    localparam int          LOCKC  = 20;

    localparam int M_WAIT  = 0;
    localparam int M_KEYS  = 1;
    localparam int M_JUDGE = 2;
    localparam int M_OPEN  = 3;
    localparam int M_ERR   = 4;
    localparam int M_LOCK  = 5;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic chk_en;
    logic unlock_seen;
    logic lock_seen;

    elc_multi_code_if #(.DIGIT_W(3)) bus ();

    elc_multi_code dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int m_mode  = M_WAIT;
    int m_fails = 0;
    int m_quiet = 0;
    int m_rem   = 0;
    int m_keys[$];

    function automatic int code_digit(input int k);
        logic [11:0] c;
        c = CODE;
        return int'(c[(LEN-1-k)*3 +: 3]);
    endfunction

    function automatic bit keys_match();
        if (m_keys.size() != LEN) return 1'b0;
        for (int k = 0; k < LEN; k++)
            if (m_keys[k] != code_digit(k)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_fail();
        m_fails = (m_fails < TRIES) ? m_fails + 1 : TRIES;
        m_mode  = M_ERR;
        m_rem   = SVAL;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_mode  = M_WAIT;
            m_fails = 0;
            m_keys.delete();
        end else begin
            case (m_mode)
                M_WAIT: if (bus.card_is_in) begin
                    m_mode  = M_KEYS;
                    m_quiet = 0;
                    m_keys.delete();
                end
                M_KEYS: begin
                    if (!bus.card_is_in) begin
                        m_mode = M_WAIT;
                    end else if (bus.enter) begin
                        m_keys.push_back(int'(bus.in));
                        m_quiet = 0;
                        if (m_keys.size() == LEN) m_mode = M_JUDGE;
                    end else begin
                        m_quiet++;
                        if (m_quiet == SVAL) model_fail();
                    end
                end
                M_JUDGE: begin
                    if (keys_match()) begin
                        m_mode  = M_OPEN;
                        m_rem   = LVAL;
                        m_fails = 0;
                    end else begin
                        model_fail();
                    end
                end
                M_OPEN: begin
                    m_rem--;
                    if (m_rem == 0) m_mode = M_WAIT;
                end
                M_ERR: begin
                    m_rem--;
                    if (m_rem == 0) begin
`ifdef ELC_LOCKOUT_EN
                        if (m_fails == TRIES) begin
                            m_mode = M_LOCK;
                            m_rem  = LOCKC;
                        end else begin
                            m_mode = M_WAIT;
                        end
`else
                        m_mode = M_WAIT;
`endif
                    end
                end
                M_LOCK: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_mode  = M_WAIT;
                        m_fails = 0;
                    end
                end
                default: m_mode = M_WAIT;
            endcase
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_unlock", int'(bus.unlock), int'(m_mode == M_OPEN));
            chk("model_error", int'(bus.error), int'(m_mode == M_ERR || m_mode == M_LOCK));
            chk("model_card_needed", int'(bus.card_is_needed), int'(m_mode == M_WAIT));
            chk("model_locked_out", int'(bus.locked_out), int'(m_mode == M_LOCK));
            if (bus.unlock === 1'b1) unlock_seen = 1'b1;
            if (bus.locked_out === 1'b1) lock_seen = 1'b1;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.unlock;
            1:       return bus.error;
            2:       return bus.locked_out;
            default: return bus.card_is_needed;
        endcase
    endfunction

    // waits for a signal to rise, then returns how many cycles it stayed high
    task automatic wait_high(input int which, input int wbound, input int cbound, output int n);
        int w;
        w = 0;
        n = 0;
        while (sig(which) !== 1'b1 && w < wbound) begin
            step();
            w++;
        end
        if (sig(which) !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wait_rise_%0d: got timeout expected rise within %0d cycles", which, wbound);
        end
        while (sig(which) === 1'b1 && n < cbound) begin
            n++;
            step();
        end
    endtask

    task automatic send_code(input int a, input int b, input int c, input int d);
        int v[4];
        v = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            bus.enter = 1'b1;
            bus.in    = 3'(v[k]);
            step();
        end
        bus.enter = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        checks      = 0;
        failures    = 0;
        chk_en      = 1'b0;
        unlock_seen = 1'b0;
        lock_seen   = 1'b0;
        reset          = 1'b1;
        bus.card_is_in = 1'b0;
        bus.enter      = 1'b0;
        bus.in         = '0;

        step();
        chk_en = 1'b1;
        step();
        chk("rst_card_needed", int'(bus.card_is_needed), 1);
        chk("rst_unlock", int'(bus.unlock), 0);
        chk("rst_error", int'(bus.error), 0);
        chk("rst_locked_out", int'(bus.locked_out), 0);
        reset = 1'b0;
        step();
        chk("idle_card_needed", int'(bus.card_is_needed), 1);

        // correct code on consecutive cycles
        bus.card_is_in = 1'b1;
        step();
        chk("entry_card_needed", int'(bus.card_is_needed), 0);
        send_code(2, 4, 1, 3);
        chk("check_cycle_unlock", int'(bus.unlock), 0);
        step();
        chk("unlock_latency", int'(bus.unlock), 1);
        n = 0;
        while (bus.unlock === 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk("unlock_len", n, 5);
        chk("after_open_idle", int'(bus.card_is_needed), 1);
        bus.card_is_in = 1'b0;
        step();

        // wrong last digit
        unlock_seen    = 1'b0;
        bus.card_is_in = 1'b1;
        step();
        send_code(2, 4, 1, 0);
        bus.card_is_in = 1'b0;
        wait_high(1, 5, 30, n);
        chk("wrong_code_err_len", n, 10);
        chk("wrong_code_no_unlock", int'(unlock_seen), 0);
        chk("model_fail_count", m_fails, 1);

        // inter-digit timeout
        bus.card_is_in = 1'b1;
        step();
        bus.enter = 1'b1;
        bus.in    = 3'd2;
        step();
        bus.enter = 1'b0;
        repeat (9) step();
        chk("timeout_early", int'(bus.error), 0);
        step();
        chk("timeout_fire", int'(bus.error), 1);
        bus.card_is_in = 1'b0;
        wait_high(3, 20, 1, n);

        // keypress on the expiry cycle keeps the entry alive
        bus.card_is_in = 1'b1;
        step();
        bus.enter = 1'b1;
        bus.in    = 3'd2;
        step();
        bus.enter = 1'b0;
        repeat (9) step();
        bus.enter = 1'b1;
        bus.in    = 3'd4;
        step();
        chk("enter_beats_timeout", int'(bus.error), 0);
        bus.in = 3'd1;
        step();
        bus.in = 3'd3;
        step();
        bus.enter = 1'b0;
        step();
        chk("late_digit_unlock", int'(bus.unlock), 1);
        chk("model_fail_cleared", m_fails, 0);
        bus.card_is_in = 1'b0;
        wait_high(3, 10, 1, n);

        // card pulled after two digits
        bus.card_is_in = 1'b1;
        step();
        bus.enter = 1'b1;
        bus.in    = 3'd2;
        step();
        bus.in = 3'd4;
        step();
        bus.enter      = 1'b0;
        bus.card_is_in = 1'b0;
        step();
        chk("card_pull_idle", int'(bus.card_is_needed), 1);
        chk("card_pull_no_err", int'(bus.error), 0);
        step();

`ifdef ELC_LOCKOUT_EN
        for (int t = 0; t < 2; t++) begin
            bus.card_is_in = 1'b1;
            step();
            send_code(2, 4, 1, 0);
            bus.card_is_in = 1'b0;
            wait_high(1, 5, 30, n);
            chk("pre_lock_err_len", n, 10);
        end
        bus.card_is_in = 1'b1;
        step();
        send_code(2, 4, 1, 0);
        bus.enter = 1'b1;
        bus.in    = 3'd2;
        wait_high(2, 20, 40, n);
        chk("lockout_len", n, 20);
        chk("lockout_exit_idle", int'(bus.card_is_needed), 1);
        bus.enter = 1'b0;
        step();
        send_code(2, 4, 1, 3);
        step();
        chk("post_lockout_unlock", int'(bus.unlock), 1);
        bus.card_is_in = 1'b0;
        wait_high(3, 10, 1, n);
`else
        lock_seen = 1'b0;
        for (int t = 0; t < 4; t++) begin
            bus.card_is_in = 1'b1;
            step();
            send_code(2, 4, 1, 0);
            bus.card_is_in = 1'b0;
            wait_high(1, 5, 30, n);
            chk("nolock_err_len", n, 10);
        end
        chk("nolock_never_locked", int'(lock_seen), 0);
`endif

        // reset in the middle of an open door
        bus.card_is_in = 1'b1;
        step();
        send_code(2, 4, 1, 3);
        step();
        chk("open_before_reset", int'(bus.unlock), 1);
        step();
        reset = 1'b1;
        step();
        chk("reset_mid_open_unlock", int'(bus.unlock), 0);
        chk("reset_mid_open_idle", int'(bus.card_is_needed), 1);
        reset          = 1'b0;
        bus.card_is_in = 1'b0;
        step();
        step();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
